// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port RAM: sticky ownership with a burst limit,
// one-cycle read return tagged to its owner. Define ARB_FIXED_PRIO_EN for fixed m0 priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [0:0] OWN0 = 1'b0;
    localparam logic [0:0] OWN1 = 1'b1;

    logic [0:0] state_reg, state_next;
    logic [3:0] burst_cnt_reg, burst_cnt_next;
    logic       rd_pend_reg, rd_tag_reg;
    logic       grant_any, grant_sel, grant_we, gnt_valid;

`ifndef ARB_FIXED_PRIO_EN
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    logic owner_req, other_req;
    assign owner_req = (state_reg == OWN1) ? m1_req : m0_req;
    assign other_req = (state_reg == OWN1) ? m0_req : m1_req;
`endif

    always_comb begin
        grant_any      = 1'b0;
        grant_sel      = state_reg;
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
`ifdef ARB_FIXED_PRIO_EN
        burst_cnt_next = 4'd0;
        if (m0_req) begin
            grant_any  = 1'b1;
            grant_sel  = 1'b0;
            state_next = OWN0;
        end else if (m1_req) begin
            grant_any  = 1'b1;
            grant_sel  = 1'b1;
            state_next = OWN1;
        end
`else
        // The owner keeps the port until it has used its burst while the other side waits.
        if (owner_req && (!other_req || burst_cnt_reg < BURST_LIMIT)) begin
            grant_any = 1'b1;
            grant_sel = state_reg;
            if (burst_cnt_reg < BURST_LIMIT)
                burst_cnt_next = burst_cnt_reg + 4'd1;
        end else if (other_req) begin
            grant_any      = 1'b1;
            grant_sel      = ~state_reg;
            state_next     = ~state_reg;
            burst_cnt_next = 4'd1;
        end else begin
            burst_cnt_next = 4'd0;
        end
`endif
    end

    assign gnt_valid = grant_any & reset;
    assign grant_we  = grant_sel ? m1_we : m0_we;

    assign m0_gnt    = gnt_valid & ~grant_sel;
    assign m1_gnt    = gnt_valid & grant_sel;
    assign mem_en    = gnt_valid;
    assign mem_we    = gnt_valid & grant_we;
    assign mem_addr  = grant_sel ? m1_addr : m0_addr;
    assign mem_wdata = grant_sel ? m1_wdata : m0_wdata;

    // Gating with reset keeps a read in flight from surfacing while reset is asserted.
    assign m0_rvalid = reset & rd_pend_reg & ~rd_tag_reg;
    assign m1_rvalid = reset & rd_pend_reg & rd_tag_reg;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= OWN0;
            burst_cnt_reg <= 4'd0;
            rd_pend_reg   <= 1'b0;
            rd_tag_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            rd_pend_reg   <= grant_any & ~grant_we;
            rd_tag_reg    <= grant_sel;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants and
// read returns (stamped with their cycle); a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [0:255];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {int cyc; int idx; logic we; logic [7:0] addr; logic [31:0] data;} gexp_t;
    typedef struct {int cyc; int idx; logic [31:0] data;} rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: registered read, preloaded while reset is low.
    always @(posedge clock) begin
        if (!reset) begin
            ram[1] <= 32'h0000_0011;
            ram[2] <= 32'h0000_0022;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor
    always @(negedge clock) begin
        gexp_t g;
        rexp_t r;
        if (reset === 1'b0) begin
            check("reset_outputs", 64'({m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid}), 64'd0);
        end else if (reset === 1'b1) begin
            if (gq.size() != 0 && gq[0].cyc == cyc) begin
                g = gq.pop_front();
                $display("grant cyc=%0d m%0d we=%0b addr=%02h data=%08h", cyc, g.idx, g.we, g.addr, g.data);
                check("gnt", 64'({m0_gnt, m1_gnt}), (g.idx == 0) ? 64'd2 : 64'd1);
                check("mem_en", 64'(mem_en), 64'd1);
                check("mem_we", 64'(mem_we), 64'(g.we));
                check("mem_addr", 64'(mem_addr), 64'(g.addr));
                if (g.we) check("mem_wdata", 64'(mem_wdata), 64'(g.data));
            end else begin
                check("idle_gnt", 64'({m0_gnt, m1_gnt, mem_en}), 64'd0);
            end
            if (rq.size() != 0 && rq[0].cyc == cyc) begin
                r = rq.pop_front();
                $display("rdata cyc=%0d m%0d data=%08h", cyc, r.idx, r.data);
                check("rvalid", 64'({m0_rvalid, m1_rvalid}), (r.idx == 0) ? 64'd2 : 64'd1);
                check("rdata", (r.idx == 0) ? 64'(m0_rdata) : 64'(m1_rdata), 64'(r.data));
            end else begin
                check("no_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_grant(input int idx, input logic we, input logic [7:0] addr, input logic [31:0] data);
        gexp_t g;
        g.cyc = cyc; g.idx = idx; g.we = we; g.addr = addr; g.data = data;
        gq.push_back(g);
    endtask

    task automatic exp_read(input int idx, input logic [31:0] data);
        rexp_t r;
        r.cyc = cyc + 1; r.idx = idx; r.data = data;
        rq.push_back(r);
    endtask

    initial begin
        int idx;
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h80; m0_wdata = 32'hA000_0080;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h90; m1_wdata = 32'hB000_0090;
        repeat (3) step();

        // Both requesting continuously: m0 x4, m1 x4, m0 x4
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            idx = 0;
`else
            idx = (i / 4) % 2;
`endif
            if (idx == 0) exp_grant(0, 1'b1, 8'h80, 32'hA000_0080);
            else          exp_grant(1, 1'b1, 8'h90, 32'hB000_0090);
            step();
        end
        m0_req = 1'b0;
        exp_grant(1, 1'b1, 8'h90, 32'hB000_0090);
        step();
        m1_req = 1'b0;
        step();

        // m1 alone: write then read back 0x10
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h10; m1_wdata = 32'hDEAD_BEEF;
        exp_grant(1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        step();
        m1_we = 1'b0;
        exp_grant(1, 1'b0, 8'h10, 32'h0);
        exp_read(1, 32'hDEAD_BEEF);
        step();
        m1_req = 1'b0;
        step();

        // m0 reads 0x01, then m1 reads 0x02 in the following cycle
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h01;
        exp_grant(0, 1'b0, 8'h01, 32'h0);
        exp_read(0, 32'h0000_0011);
        step();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h02;
        exp_grant(1, 1'b0, 8'h02, 32'h0);
        exp_read(1, 32'h0000_0022);
        step();
        m1_req = 1'b0;
        step();

        // Reset right after a granted m1 read: the read is discarded, owner returns to m0
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h02;
        exp_grant(1, 1'b0, 8'h02, 32'h0);
        step();
        reset = 1'b0;
        m1_req = 1'b0;
        step();
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h20; m0_wdata = 32'h0000_0001;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h21; m1_wdata = 32'h0000_0002;
        exp_grant(0, 1'b1, 8'h20, 32'h0000_0001);
        step();
        m0_req = 1'b0;
        exp_grant(1, 1'b1, 8'h21, 32'h0000_0002);
        step();
        m1_req = 1'b0;
        step();
        step();

        check("grant_queue_drained", 64'(gq.size()), 64'd0);
        check("read_queue_drained", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
